// File: rtl/datapath_gray_pkg.sv
// datapath_gray_pkg: mode constants and width-generic gray/binary conversion helpers
package datapath_gray_pkg;
  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;
  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction
  // Callers zero-extend narrower words, so the unused upper bits contribute nothing to the prefix XOR
  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b[63] = g[63];
    for (int i = 62; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_skid_fifo.sv
// gray_skid_fifo: two-entry FIFO with registered full flag and head-driven output
module gray_skid_fifo
  import datapath_gray_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] head, tail;
  logic [1:0] cnt, cnt_nxt;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && cnt != 2'd0;
  assign cnt_nxt = cnt + 2'(push) - 2'(pop);
  assign rd_data = head;
  assign empty = cnt == 2'd0;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      full <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      full <= cnt_nxt == 2'd2;
      if (pop) head <= (cnt == 2'd2) ? tail : wr_data;
      else if (push && cnt == 2'd0) head <= wr_data;
      if (push && cnt_nxt == 2'd2) tail <= wr_data;
    end
  end
endmodule

// File: rtl/datapath_gray_param.sv
// datapath_gray_param: per-frame gray/binary converter feeding a two-entry output FIFO
module datapath_gray_param
  import datapath_gray_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FCNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic              mode_in,
  output logic              busy_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sof_out,
  input  logic              busy_in,
  output logic [FCNT_W-1:0] frame_cnt
);
  logic mode_q, mode_eff, accept, empty;
  logic [DATA_W-1:0] conv;
  assign accept = valid_in && !busy_out;
  // An SOF beat switches mode for itself, not just for the beats after it
  assign mode_eff = sof_in ? mode_in : mode_q;
  assign conv = DATA_W'(mode_eff == MODE_GRAY2BIN ? gray2bin(64'(data_in)) : bin2gray(64'(data_in)));
  assign valid_out = !empty;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q <= MODE_BIN2GRAY;
      frame_cnt <= '0;
    end else if (accept && sof_in) begin
      mode_q <= mode_in;
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
  gray_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .wr_en(accept),
    .wr_data({sof_in, conv}),
    .rd_en(!busy_in),
    .rd_data({sof_out, data_out}),
    .empty(empty),
    .full(busy_out)
  );
endmodule

// File: tb/tb_datapath_gray_param.sv
// tb_datapath_gray_param: scoreboard bench with directed conversion, stall, mode and reset vectors
module tb_datapath_gray_param;
  localparam int DW = 8;
  localparam int FW = 2;
  logic i_clk = 0, i_rst_n = 0, valid_in = 0, sof_in = 0, mode_in = 0, busy_in = 0;
  logic [DW-1:0] data_in = '0, data_out;
  logic busy_out, valid_out, sof_out;
  logic [FW-1:0] frame_cnt, efc = '0;
  logic [DW:0] q[$], held;
  logic stall = 0;
  int errors = 0, checks = 0;

  datapath_gray_param #(.DATA_W(DW), .FCNT_W(FW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .mode_in(mode_in), .busy_out(busy_out), .data_out(data_out),
    .valid_out(valid_out), .sof_out(sof_out), .busy_in(busy_in), .frame_cnt(frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Inputs change 1 time unit after posedge, so at negedge they hold for the coming edge
  always @(negedge i_clk) begin
    if (!i_rst_n) stall = 0;
    else begin
      if (stall && valid_out) chk("hold", {sof_out, data_out}, held);
      if (valid_out && !busy_in) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", {sof_out, data_out});
        end else chk("out", {sof_out, data_out}, q.pop_front());
      end
      stall = valid_out && busy_in;
      held = {sof_out, data_out};
    end
  end

  task automatic send(input logic [7:0] d, input logic s, input logic m, input logic [7:0] e);
    int n = 0;
    logic acc;
    valid_in = 1;
    data_in = d;
    sof_in = s;
    mode_in = m;
    do begin
      acc = !busy_out;
      @(posedge i_clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    else begin
      q.push_back({s, e});
      chk("lat_valid", valid_out, 1);
      if (s) begin
        efc++;
        chk("frame_cnt", frame_cnt, efc);
      end
    end
    valid_in = 0;
    sof_in = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_data", data_out, 0);
    i_rst_n = 1;
    // binary to gray
    send(8'h00, 1, 0, 8'h00);
    send(8'hFF, 0, 0, 8'h80);
    send(8'h1F, 0, 0, 8'h10);
    send(8'h3F, 0, 0, 8'h20);
    send(8'h7F, 0, 0, 8'h40);
    drain();
    // gray to binary
    send(8'h80, 1, 1, 8'hFF);
    send(8'h10, 0, 0, 8'h1F);
    send(8'h20, 0, 0, 8'h3F);
    send(8'h40, 0, 0, 8'h7F);
    drain();
    // downstream stall
    busy_in = 1;
    send(8'h01, 1, 0, 8'h01);
    send(8'h02, 0, 0, 8'h03);
    chk("full_busy", busy_out, 1);
    fork
      send(8'h03, 0, 0, 8'h02);
      begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("stall_busy", busy_out, 1);
        chk("stall_head", data_out, 8'h01);
        busy_in = 0;
      end
    join
    drain();
    // mode only changes on SOF
    send(8'h04, 1, 0, 8'h06);
    send(8'h04, 0, 1, 8'h06);
    send(8'h07, 0, 1, 8'h04);
    send(8'h06, 1, 1, 8'h04);
    send(8'h06, 0, 0, 8'h04);
    drain();
    // reset with a full FIFO
    busy_in = 1;
    send(8'h11, 1, 0, 8'h19);
    send(8'h22, 0, 0, 8'h33);
    chk("pre_rst_busy", busy_out, 1);
    i_rst_n = 0;
    valid_in = 1;
    sof_in = 1;
    data_in = 8'h55;
    @(posedge i_clk);
    #1;
    q.delete();
    efc = '0;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_fcnt", frame_cnt, 0);
    chk("mid_rst_data", data_out, 0);
    valid_in = 0;
    sof_in = 0;
    i_rst_n = 1;
    busy_in = 0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      chk("post_rst_valid", valid_out, 0);
    end
    chk("post_rst_fcnt", frame_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/datapath_gray_param.md
DATAPATH_GRAY_PARAM -- requirements
Module: datapath_gray_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data path width in bits (legal range 2..64).
REQ-002 SHALL have parameter FCNT_W, default 8, meaning width of the accepted-frame counter.
REQ-003 SHALL provide one clock; reset is synchronous and active-low.
REQ-004 i_clk  input  1  clock, all state changes on rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 data_in  input  DATA_W  input word.
REQ-007 valid_in  input  1  data_in/sof_in/mode_in are valid.
REQ-008 sof_in  input  1  first beat of a frame.
REQ-009 mode_in  input  1  conversion mode: 0 = binary-to-gray, 1 = gray-to-binary; sampled only on SOF beats.
REQ-010 busy_out  output  1  upstream back-pressure; no input is accepted while high.
REQ-011 data_out  output  DATA_W  converted word.
REQ-012 valid_out  output  1  data_out/sof_out are valid.
REQ-013 sof_out  output  1  sof_in delayed with its beat.
REQ-014 busy_in  input  1  downstream back-pressure.
REQ-015 frame_cnt  output  FCNT_W  number of SOF beats accepted since reset, modulo 2^FCNT_W.

Function
REQ-016 An input beat SHALL be accepted on a rising edge where valid_in=1 and busy_out=0; input while busy_out=1 is ignored.
REQ-017 An output beat SHALL be consumed on a rising edge where valid_out=1 and busy_in=0; data_out/sof_out SHALL hold stable while valid_out=1 and busy_in=1.
REQ-018 Accepted beats SHALL enter a 2-entry FIFO; the head drives data_out/sof_out; valid_out = (count != 0); busy_out = (count == 2), driven from a register.
REQ-019 Latency SHALL be one cycle: a beat accepted at edge N into an empty FIFO appears with valid_out=1 in the cycle after edge N.
REQ-020 Simultaneous accept and consume SHALL leave count unchanged and preserve order; no beat lost or duplicated.
REQ-021 Binary-to-gray SHALL compute g = b XOR (b >> 1); gray-to-binary SHALL compute b[i] = XOR of g[DATA_W-1:i].
REQ-022 Conversion SHALL be applied at acceptance and the converted word stored in the FIFO.
REQ-023 The active mode register SHALL load mode_in on every accepted SOF beat, and that beat SHALL already use the new mode.
REQ-024 Non-SOF beats SHALL use the active mode; mode_in on non-SOF beats SHALL be ignored.
REQ-025 frame_cnt SHALL increment by one on each accepted SOF beat and wrap from all-ones to zero.
REQ-026 A frame SHALL need no explicit end; a new SOF SHALL terminate the previous frame.
REQ-027 When busy_in=1 persists, the FIFO SHALL fill to 2, then busy_out=1 until a consume frees an entry; busy_out falls the cycle after that consume.

Reset
REQ-028 While i_rst_n=0 at a rising edge, the block SHALL clear FIFO count, valid_out=0, sof_out=0, data_out=0, busy_out=0, frame_cnt=0, active mode=0.
REQ-029 Reset asserted mid-frame or with a full FIFO SHALL discard all stored beats; no beat SHALL appear after reset release until a new accept.
REQ-030 Beats presented in the cycle reset is asserted SHALL NOT be accepted.

Structure
REQ-031 A shared package datapath_gray_pkg SHALL hold the mode constants (MODE_BIN2GRAY=0, MODE_GRAY2BIN=1) and the bin2gray/gray2bin width-generic functions.
REQ-032 The 2-entry FIFO SHALL be a sub-module gray_skid_fifo, parametrised by width (DATA_W+1 for data plus sof).

Verification
REQ-033 Mode 0, SOF then 8'h00,8'hFF,8'h1F,8'h3F,8'h7F, busy_in=0 -> data_out 8'h00,8'h80,8'h10,8'h20,8'h40, one-cycle latency, sof_out on first only, frame_cnt=1.
REQ-034 Mode 1 SOF, inputs 8'h80,8'h10,8'h20,8'h40 -> data_out 8'hFF,8'h1F,8'h3F,8'h7F.
REQ-035 busy_in=1 while streaming 8'h01,8'h02,8'h03 -> busy_out=1 after two accepts, 8'h03 held off; release -> outputs in order, none lost or duplicated.
REQ-036 mode_in toggled on non-SOF beats -> no effect; next SOF with mode_in=1 switches conversion on that beat.
REQ-037 FCNT_W=2, five SOF frames -> frame_cnt 1,2,3,0,1.
REQ-038 i_rst_n=0 with FIFO full and busy_in=1 -> next cycle valid_out=0, busy_out=0, frame_cnt=0, data_out=0.
